// File: rtl/data_memory_lsu.sv
// Byte-addressed RV32 data memory for the MEM stage: valid/ready request, one-cycle response strobe,
// fault detection and WAIT_CYCLES extra latency. Define DMEM_PERF_EN to add load/store/fault counters.
module data_memory_lsu #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_faults
`endif
);

  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       data_q;
  logic              fault_q;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [ADDR_W-3:0] word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic [1:0]        lane;
  logic              fault;
  logic              accept;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;

  // Place the selected byte/half at bit 0 and extend it; word loads ignore uns.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] ln,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] shifted;
    shifted = word >> {ln, 3'b000};
    case (size)
      2'b00:   load_extend = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_extend = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   load_extend = word;
      default: load_extend = '0;
    endcase
  endfunction

  assign word_idx  = req_addr[ADDR_W-1:2];
  assign mem_idx   = word_idx[MEM_AW-1:0];
  assign lane      = req_addr[1:0];
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && rst_n;

  assign fault = (req_size == 2'b11)
              || (req_size == 2'b01 && lane[0])
              || (req_size == 2'b10 && lane != 2'b00)
              || (word_idx >= DEPTH_IDX);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    byte_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  // NOTE: storage has no reset; contents survive rst_n and only committed stores change them.
  always_ff @(posedge clk) begin
    if (accept && req_write && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[mem_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt == '0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The response payload is fully resolved at accept, so WAIT only delays the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      cnt     <= CNT_LOAD;
      fault_q <= fault;
      data_q  <= (req_write || fault) ? '0 : load_extend(mem[mem_idx], lane, req_size, req_unsigned);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? data_q : '0;
  assign rsp_fault = rsp_valid && fault_q;

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_faults <= '0;
    end else if (accept) begin
      if (fault)          perf_faults <= perf_faults + 32'd1;
      else if (req_write) perf_stores <= perf_stores + 32'd1;
      else                perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: a WAIT_CYCLES=0 instance driven from a vector table and a
// WAIT_CYCLES=3 instance exercised with hand-written latency and reset sequences.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid0, valid3;
  logic        rw, ru;
  logic [1:0]  rs;
  logic [31:0] ra, rwd;
  logic        ready0, ready3, rv0, rv3, rf0, rf3;
  logic [31:0] rd0, rd3;
`ifdef DMEM_PERF_EN
  logic [31:0] pl0, ps0, pf0, pl3, ps3, pf3;
`endif

  always #5 clk = ~clk;

  data_memory_lsu #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0), .req_write(rw),
    .req_size(rs), .req_unsigned(ru), .req_addr(ra), .req_wdata(rwd),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_fault(rf0)
`ifdef DMEM_PERF_EN
    , .perf_loads(pl0), .perf_stores(ps0), .perf_faults(pf0)
`endif
  );

  data_memory_lsu #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3), .req_write(rw),
    .req_size(rs), .req_unsigned(ru), .req_addr(ra), .req_wdata(rwd),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_fault(rf3)
`ifdef DMEM_PERF_EN
    , .perf_loads(pl3), .perf_stores(ps3), .perf_faults(pf3)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // One full transaction; lat counts cycles from accept to the rsp_valid cycle (capped at 20).
  task automatic do_req(input int sel, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic f, output int lat);
    @(posedge clk); #1;
    rw = w; rs = sz; ru = u; ra = a; rwd = wd;
    if (sel == 0) valid0 = 1'b1;
    else          valid3 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0; valid3 = 1'b0;
    rw = 1'b1; rs = 2'b00; ru = 1'b1; ra = 32'h0000_0010; rwd = 32'hFFFF_FFFF;
    lat = 1;
    while (!((sel == 0) ? rv0 : rv3) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = (sel == 0) ? rd0 : rd3;
    f  = (sel == 0) ? rf0 : rf3;
  endtask

  typedef struct {
    string       name;
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_f);
    vec_t v;
    v.name = name; v.w = w; v.sz = sz; v.u = u; v.a = a; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_f = exp_f;
    vecs.push_back(v);
  endtask

  logic [31:0] rd;
  logic        f;
  int          lat;
  int          seen;

  initial begin
    rst_n = 1'b0; valid0 = 1'b0; valid3 = 1'b0;
    rw = 1'b0; rs = 2'b00; ru = 1'b0; ra = '0; rwd = '0;

    //        name              w     sz     u     addr          wdata          exp_rdata      fault
    add("sw_10",           1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    add("lw_10",           1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    add("sb_13",           1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h1234_56AB, 32'h0000_0000, 1'b0);
    add("lb_13",           1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'hFFFF_FFAB, 1'b0);
    add("lbu_13",          1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_00AB, 1'b0);
    add("lw_10_b",         1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hABAD_BEEF, 1'b0);
    add("sh_11_mis",       1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_5555, 32'h0000_0000, 1'b1);
    add("lw_12_mis",       1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1);
    add("lw_10_c",         1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hABAD_BEEF, 1'b0);
    add("sw_00",           1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h0123_4567, 32'h0000_0000, 1'b0);
    add("sw_1000_oor",     1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h1111_1111, 32'h0000_0000, 1'b1);
    add("lw_00",           1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,         32'h0123_4567, 1'b0);
    add("ld_size11",       1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1);
    add("st_size11",       1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b1);
    add("lw_10_d",         1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hABAD_BEEF, 1'b0);
    add("sw_14",           1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h8765_4321, 32'h0000_0000, 1'b0);
    add("sh_16",           1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'h1234_CAFE, 32'h0000_0000, 1'b0);
    add("lh_16",           1'b0, 2'b01, 1'b0, 32'h0000_0016, 32'h0,         32'hFFFF_CAFE, 1'b0);
    add("lhu_16",          1'b0, 2'b01, 1'b1, 32'h0000_0016, 32'h0,         32'h0000_CAFE, 1'b0);
    add("lh_14",           1'b0, 2'b01, 1'b0, 32'h0000_0014, 32'h0,         32'h0000_4321, 1'b0);
    add("lb_15",           1'b0, 2'b00, 1'b0, 32'h0000_0015, 32'h0,         32'h0000_0043, 1'b0);
    add("lb_16",           1'b0, 2'b00, 1'b0, 32'h0000_0016, 32'h0,         32'hFFFF_FFFE, 1'b0);
    add("lw_14_uns",       1'b0, 2'b10, 1'b1, 32'h0000_0014, 32'h0,         32'hCAFE_4321, 1'b0);
    add("lhu_13_mis",      1'b0, 2'b01, 1'b1, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1);
    add("sw_ffc_last",     1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'h8000_0000, 32'h0000_0000, 1'b0);
    add("lb_fff",          1'b0, 2'b00, 1'b0, 32'h0000_0FFF, 32'h0,         32'hFFFF_FF80, 1'b0);
    add("lbu_ffc",         1'b0, 2'b00, 1'b1, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_ready0", ready0, 1'b1);
    check_bit("rst_valid0", rv0, 1'b0);
    check("rst_rdata0", rd0, 32'h0);
    check_bit("rst_fault0", rf0, 1'b0);
    check_bit("rst_ready3", ready3, 1'b1);
    check_bit("rst_valid3", rv3, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_req(0, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rd, f, lat);
      check({vecs[i].name, "_lat"}, lat, 32'd1);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      check_bit({vecs[i].name, "_fault"}, f, vecs[i].exp_f);
    end

    // WAIT_CYCLES=3: store, then a load watched cycle by cycle.
    do_req(3, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h5AA5_F00F, rd, f, lat);
    check("w3_sw_lat", lat, 32'd4);
    check_bit("w3_sw_fault", f, 1'b0);

    @(posedge clk); #1;
    rw = 1'b0; rs = 2'b10; ru = 1'b0; ra = 32'h0000_0020; valid3 = 1'b1;
    check_bit("w3_ready_t", ready3, 1'b1);
    @(posedge clk); #1;
    valid3 = 1'b0; ra = 32'h0000_0000;
    for (int k = 1; k <= 5; k++) begin
      check_bit($sformatf("w3_ready_t+%0d", k), ready3, (k == 5));
      check_bit($sformatf("w3_valid_t+%0d", k), rv3, (k == 4));
      if (k == 4) begin
        check("w3_lw_rdata", rd3, 32'h5AA5_F00F);
        check_bit("w3_lw_fault", rf3, 1'b0);
      end
      @(posedge clk); #1;
    end

    // Reset during WAIT: committed store survives, pending response is dropped.
    rw = 1'b1; rs = 2'b10; ra = 32'h0000_0024; rwd = 32'h1357_2468; valid3 = 1'b1;
    @(posedge clk); #1;
    valid3 = 1'b0;
    check_bit("w3_in_wait", ready3, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_bit("mid_rst_valid", rv3, 1'b0);
    check("mid_rst_rdata", rd3, 32'h0);
    check_bit("mid_rst_fault", rf3, 1'b0);
    check_bit("mid_rst_ready", ready3, 1'b1);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (rv3) seen++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_rsp", seen, 32'd0);
    do_req(3, 1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0, rd, f, lat);
    check("mid_rst_store_kept", rd, 32'h1357_2468);
    check("mid_rst_lw_lat", lat, 32'd4);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, rd, f, lat);
    check("mem_kept_after_rst", rd, 32'hABAD_BEEF);

`ifdef DMEM_PERF_EN
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, rd, f, lat);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, rd, f, lat);
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h0, rd, f, lat);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h0, rd, f, lat);
    check("perf_loads", pl0, 32'd2);
    check("perf_stores", ps0, 32'd1);
    check("perf_faults", pf0, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("perf_loads_rst", pl0, 32'd0);
    check("perf_stores_rst", ps0, 32'd0);
    check("perf_faults_rst", pf0, 32'd0);
    check("perf3_loads_rst", pl3, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
